// File: rtl/fp_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_compare_pipe
//  Description : Pipelined IEEE-754 comparator with valid/ready handshakes.
//                Run-time predicate select (EQ/LT/LE/GT/GE/NE/UN/reserved),
//                configurable exponent/mantissa widths and pipeline depth,
//                full backpressure with no bubbles.
//                Optional macro FP_COMPARE_INVALID_FLAG_EN adds the pipelined
//                'invalid' exception output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_compare_pipe #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int LATENCY  = 2,
    parameter int RESULT_W = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [EXP_W+MAN_W:0]    value1,
    input  logic [EXP_W+MAN_W:0]    value2,
    input  logic [2:0]              op,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [RESULT_W-1:0]     result
`ifdef FP_COMPARE_INVALID_FLAG_EN
    ,
    output logic                    invalid
`endif
);

    localparam int c_w = 1 + EXP_W + MAN_W;

    localparam logic [2:0] c_op_eq = 3'd0;
    localparam logic [2:0] c_op_lt = 3'd1;
    localparam logic [2:0] c_op_le = 3'd2;
    localparam logic [2:0] c_op_gt = 3'd3;
    localparam logic [2:0] c_op_ge = 3'd4;
    localparam logic [2:0] c_op_ne = 3'd5;
    localparam logic [2:0] c_op_un = 3'd6;

    // Map a float onto an unsigned key whose ordering matches the numeric
    // ordering; both zeros share the +0 key so they compare equal.
    function automatic logic [c_w-1:0] order_key(input logic [c_w-1:0] v);
        logic [c_w-1:0] k;
        if (v[c_w-2:0] == '0) begin
            k = {1'b1, {(c_w-1){1'b0}}};
        end else if (v[c_w-1]) begin
            k = ~v;
        end else begin
            k = {1'b1, v[c_w-2:0]};
        end
        return k;
    endfunction

    logic [c_w-1:0]     w_key_a;
    logic [c_w-1:0]     w_key_b;
    logic               w_nan_a;
    logic               w_nan_b;
    logic               w_unord;
    logic               w_eq;
    logic               w_lt;
    logic               w_pred;
    logic [LATENCY-1:0] w_adv;

    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_pred;

    assign w_nan_a = (&value1[c_w-2:MAN_W]) && (|value1[MAN_W-1:0]);
    assign w_nan_b = (&value2[c_w-2:MAN_W]) && (|value2[MAN_W-1:0]);
    assign w_unord = w_nan_a || w_nan_b;
    assign w_key_a = order_key(value1);
    assign w_key_b = order_key(value2);
    assign w_eq    = (w_key_a == w_key_b);
    assign w_lt    = (w_key_a <  w_key_b);

    // Predicate select; any NaN forces all ordered predicates false.
    always_comb begin
        w_pred = 1'b0;
        case (op)
            c_op_eq: w_pred = !w_unord && w_eq;
            c_op_lt: w_pred = !w_unord && w_lt;
            c_op_le: w_pred = !w_unord && (w_lt || w_eq);
            c_op_gt: w_pred = !w_unord && !w_lt && !w_eq;
            c_op_ge: w_pred = !w_unord && !w_lt;
            c_op_ne: w_pred = w_unord || !w_eq;
            c_op_un: w_pred = w_unord;
            default: w_pred = 1'b0;
        endcase
    end

`ifdef FP_COMPARE_INVALID_FLAG_EN
    logic               w_snan_any;
    logic               w_ordered_op;
    logic               w_inv;
    logic [LATENCY-1:0] r_inv;

    // Signalling NaN: NaN with the fraction MSB clear.
    assign w_snan_any   = (w_nan_a && !value1[MAN_W-1]) || (w_nan_b && !value2[MAN_W-1]);
    assign w_ordered_op = (op == c_op_lt) || (op == c_op_le) ||
                          (op == c_op_gt) || (op == c_op_ge);
    assign w_inv        = (w_unord && w_ordered_op) || w_snan_any;
    assign invalid      = r_inv[LATENCY-1];
`endif

    // Stage i may load when any stage from i to the output is empty, or the
    // output is being taken; this lets a full pipe stream without bubbles.
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_adv[i] = m_ready;
            for (int j = 0; j < LATENCY; j++) begin
                if ((j >= i) && !r_valid[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign s_ready = w_adv[0] && !areset;
    assign m_valid = r_valid[LATENCY-1];
    assign result  = {{(RESULT_W-1){1'b0}}, r_pred[LATENCY-1]};

    // Pipeline registers: stage 0 captures the decoded predicate, later
    // stages shift forward whenever allowed to advance.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_valid <= '0;
            r_pred  <= '0;
`ifdef FP_COMPARE_INVALID_FLAG_EN
            r_inv   <= '0;
`endif
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= s_valid;
                r_pred[0]  <= w_pred;
`ifdef FP_COMPARE_INVALID_FLAG_EN
                r_inv[0]   <= w_inv;
`endif
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    r_pred[i]  <= r_pred[i-1];
`ifdef FP_COMPARE_INVALID_FLAG_EN
                    r_inv[i]   <= r_inv[i-1];
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_compare_pipe
//  Description : Scoreboard bench for fp_compare_pipe (32-bit, LATENCY 2)
//                plus two 64-bit instances (LATENCY 1 and 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_compare_pipe;

    localparam int L    = 2;
    localparam int L64A = 1;
    localparam int L64B = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] value1;
    logic [31:0] value2;
    logic [2:0]  op;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] result;

    logic        s_valid64;
    logic [63:0] v1_64;
    logic [63:0] v2_64;
    logic [2:0]  op64;
    logic        m_ready64;
    logic        s_ready64a, s_ready64b;
    logic        m_valid64a, m_valid64b;
    logic [31:0] result64a, result64b;

`ifdef FP_COMPARE_INVALID_FLAG_EN
    logic        inv, inv64a, inv64b;
`endif

    always #5 aclk = ~aclk;

    fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(L), .RESULT_W(32)) dut (
        .aclk(aclk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready),
        .value1(value1), .value2(value2), .op(op), .m_valid(m_valid),
        .m_ready(m_ready), .result(result)
`ifdef FP_COMPARE_INVALID_FLAG_EN
        , .invalid(inv)
`endif
    );

    fp_compare_pipe #(.EXP_W(11), .MAN_W(52), .LATENCY(L64A), .RESULT_W(32)) dut64a (
        .aclk(aclk), .areset(areset), .s_valid(s_valid64), .s_ready(s_ready64a),
        .value1(v1_64), .value2(v2_64), .op(op64), .m_valid(m_valid64a),
        .m_ready(m_ready64), .result(result64a)
`ifdef FP_COMPARE_INVALID_FLAG_EN
        , .invalid(inv64a)
`endif
    );

    fp_compare_pipe #(.EXP_W(11), .MAN_W(52), .LATENCY(L64B), .RESULT_W(32)) dut64b (
        .aclk(aclk), .areset(areset), .s_valid(s_valid64), .s_ready(s_ready64b),
        .value1(v1_64), .value2(v2_64), .op(op64), .m_valid(m_valid64b),
        .m_ready(m_ready64), .result(result64b)
`ifdef FP_COMPARE_INVALID_FLAG_EN
        , .invalid(inv64b)
`endif
    );

    typedef struct {
        logic pred;
        logic inv;
        int   acc;
        bit   lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   n_dep    = 0;
    bit   sr_en    = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model by sign/magnitude reasoning; returns {invalid, pred}.
    function automatic logic [1:0] fpm(input logic [63:0] a, input logic [63:0] b,
                                       input logic [2:0] o, input int ew, input int mw);
        int          sbit;
        logic [63:0] mask, emax, fmask, ma, mb;
        logic        na, nb, sna, snb, za, zb, sga, sgb, eq, lt, un, p, iv;
        sbit  = ew + mw;
        mask  = (64'd1 << sbit) - 64'd1;
        emax  = (64'd1 << ew) - 64'd1;
        fmask = (64'd1 << mw) - 64'd1;
        ma    = a & mask;
        mb    = b & mask;
        na    = ((ma >> mw) == emax) && ((ma & fmask) != 64'd0);
        nb    = ((mb >> mw) == emax) && ((mb & fmask) != 64'd0);
        sna   = na && !a[mw-1];
        snb   = nb && !b[mw-1];
        za    = (ma == 64'd0);
        zb    = (mb == 64'd0);
        sga   = a[sbit];
        sgb   = b[sbit];
        if (za && zb) begin
            eq = 1'b1; lt = 1'b0;
        end else if (sga != sgb) begin
            eq = 1'b0; lt = sga;
        end else begin
            eq = (ma == mb);
            lt = sga ? (ma > mb) : (ma < mb);
        end
        un = na || nb;
        case (o)
            3'd0: p = !un && eq;
            3'd1: p = !un && lt;
            3'd2: p = !un && (lt || eq);
            3'd3: p = !un && !lt && !eq;
            3'd4: p = !un && !lt;
            3'd5: p = un || !eq;
            3'd6: p = un;
            default: p = 1'b0;
        endcase
        iv = (un && (o >= 3'd1) && (o <= 3'd4)) || sna || snb;
        return {iv, p};
    endfunction

    function automatic logic [31:0] pick32();
        logic [31:0] sp [12] = '{32'h00000000, 32'h80000000, 32'h3f800000, 32'hbf800000,
                                 32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h7f800001,
                                 32'h00000001, 32'h80000001, 32'h007fffff, 32'hc2c80000};
        if ($urandom_range(0, 2) == 0) return $urandom();
        return sp[$urandom_range(0, 11)];
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // Handshake counters for the occupancy-based s_ready expectation.
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            n_acc <= 0;
            n_dep <= 0;
        end else begin
            if (s_valid && s_ready) n_acc <= n_acc + 1;
            if (m_valid && m_ready) n_dep <= n_dep + 1;
        end
    end

    // Output monitor: scoreboard pop, stall stability, s_ready and idle checks.
    exp_t e;
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 64'(m_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'(result), 64'(e.pred));
`ifdef FP_COMPARE_INVALID_FLAG_EN
                    check("invalid", 64'(inv), 64'(e.inv));
`endif
                    if (e.lat) check("latency", 64'(cyc - e.acc), 64'(L - 1));
                end
            end else if (m_valid && sb_q.size() > 0) begin
                check("stall_hold", 64'(result), 64'(sb_q[0].pred));
            end
            if (sr_en) begin
                check("s_ready", 64'(s_ready), 64'(m_ready || ((n_acc - n_dep) < L)));
                if (n_acc == n_dep) check("mvalid_empty", 64'(m_valid), 64'd0);
            end
        end
    end

    // Offer one transaction; the expected result is queued when it is taken.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] o, input bit lat);
        exp_t        ex;
        logic [1:0]  r;
        bit          done;
        int          tries;
        done    = 1'b0;
        tries   = 0;
        s_valid = 1'b1;
        value1  = a;
        value2  = b;
        op      = o;
        r       = fpm({32'd0, a}, {32'd0, b}, o, 8, 23);
        while (!done) begin
            @(negedge aclk);
            if (s_ready) begin
                ex.pred = r[0];
                ex.inv  = r[1];
                ex.acc  = cyc + 1;
                ex.lat  = lat;
                sb_q.push_back(ex);
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 100) begin
                    check("send_timeout", 64'(s_ready), 64'd1);
                    done = 1'b1;
                end
            end
            @(posedge aclk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge aclk);
            #1;
            t++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    logic [31:0] da  [16] = '{32'h3fc00000, 32'h40200000, 32'h3fc00000, 32'h3fc00000,
                              32'h3fc00000, 32'h00000000, 32'hbf800000, 32'hff800000,
                              32'h7fc00000, 32'h7fc00000, 32'h7fc00000, 32'h7fc00000,
                              32'h7f800001, 32'h00000001, 32'h3f800000, 32'h80000000};
    logic [31:0] db  [16] = '{32'h40200000, 32'h3fc00000, 32'h3fc00000, 32'h3fc00000,
                              32'h3fc00000, 32'h80000000, 32'h3f800000, 32'hc2c80000,
                              32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000,
                              32'h3f800000, 32'h00000002, 32'h3f800000, 32'h00000001};
    logic [2:0]  dop [16] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd0, 3'd0, 3'd1, 3'd3,
                              3'd1, 3'd0, 3'd5, 3'd6, 3'd0, 3'd1, 3'd7, 3'd1};

    logic [63:0] swa [3] = '{64'h3ff8000000000000, 64'h4004000000000000, 64'h3ff0000000000000};
    logic [63:0] swb [3] = '{64'h4004000000000000, 64'h3ff8000000000000, 64'h3ff0000000000000};
    logic [2:0]  swo [3] = '{3'd3, 3'd3, 3'd7};

    bit rnd_done;

    initial begin
        int          lat_a, lat_b;
        logic [31:0] res_a, res_b;
        logic [1:0]  r64;
        logic [31:0] ra;

        areset    = 1'b1;
        s_valid   = 1'b0;
        value1    = '0;
        value2    = '0;
        op        = '0;
        m_ready   = 1'b1;
        s_valid64 = 1'b0;
        v1_64     = '0;
        v2_64     = '0;
        op64      = '0;
        m_ready64 = 1'b1;

        repeat (2) @(posedge aclk);
        #1;
        check("rst_mvalid", 64'(m_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_sready", 64'(s_ready), 64'd0);
        areset = 1'b0;
        sr_en  = 1'b1;
        @(negedge aclk);
        check("sready_release", 64'(s_ready), 64'd1);
        @(posedge aclk);
        #1;

        // Directed vectors, one at a time, with latency checking.
        for (int i = 0; i < 16; i++) begin
            send(da[i], db[i], dop[i], 1'b1);
            drain();
        end

        // Eight back-to-back with a five-cycle output stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = pick32();
                    send(ra, pick32(), 3'($urandom_range(0, 7)), 1'b0);
                end
            end
            begin
                repeat (3) @(posedge aclk);
                #1 m_ready = 1'b0;
                repeat (5) @(posedge aclk);
                #1 m_ready = 1'b1;
            end
        join
        drain();

        // Random stream with random output backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    ra = pick32();
                    send(ra, ($urandom_range(0, 4) == 0) ? ra : pick32(),
                         3'($urandom_range(0, 7)), 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge aclk);
                    #1 m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        drain();

        // Reset with two transactions in flight.
        send(32'h40200000, 32'h3fc00000, 3'd3, 1'b0);
        send(32'h3f800000, 32'h3f800000, 3'd0, 1'b0);
        areset = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_mvalid", 64'(m_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_sready", 64'(s_ready), 64'd0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("midrst_sready_rel", 64'(s_ready), 64'd1);
        repeat (6) @(posedge aclk);
        #1;

        // Double-precision instances with LATENCY 1 and 4.
        for (int i = 0; i < 3; i++) begin
            s_valid64 = 1'b1;
            v1_64     = swa[i];
            v2_64     = swb[i];
            op64      = swo[i];
            r64       = fpm(swa[i], swb[i], swo[i], 11, 52);
            @(negedge aclk);
            check("sw_sready_l1", 64'(s_ready64a), 64'd1);
            check("sw_sready_l4", 64'(s_ready64b), 64'd1);
            @(posedge aclk);
            #1;
            s_valid64 = 1'b0;
            lat_a = -1;
            lat_b = -1;
            res_a = '1;
            res_b = '1;
            for (int k = 0; k < 8; k++) begin
                if (m_valid64a && lat_a < 0) begin lat_a = k; res_a = result64a; end
                if (m_valid64b && lat_b < 0) begin lat_b = k; res_b = result64b; end
                @(posedge aclk);
                #1;
            end
            check("sw_lat_l1", 64'(lat_a), 64'(L64A - 1));
            check("sw_lat_l4", 64'(lat_b), 64'(L64B - 1));
            check("sw_res_l1", 64'(res_a), 64'(r64[0]));
            check("sw_res_l4", 64'(res_b), 64'(r64[0]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
